// File: rtl/mips_regfile_pkg.sv
// mips_regfile_pkg
// Shared constants and helpers for the scoreboarded MIPS register file.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default register width and index width
//   ZERO_REG                        : hard-wired zero register index
//   DBG_V0                          : default register mirrored on the debug port (v0)
//   byte_merge()                    : one byte lane of a partial write; the write path
//                                     and the optional bypass path both use it, so the
//                                     two always produce the same merged value
package mips_regfile_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int ZERO_REG       = 0;
   localparam int DBG_V0         = 2;

   function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                             input logic [7:0] new_byte,
                                             input logic       byte_en);
      return byte_en ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/mips_scoreboard.sv
// mips_scoreboard
// Pending bit per register, marking an outstanding multi-cycle write.
//   clk, reset     : clock, synchronous active-high reset
//   set_en/set_idx : reserve a register (index 0 ignored)
//   clr_en/clr_idx : completion of a reservation
//   pending        : registered pending vector (bit 0 always 0)
//   pending_count  : registered popcount of pending
// A set and a clear on the same index in one cycle leave the bit set: the new
// reservation overlaps the completion of the old one.
module mips_scoreboard
   import mips_regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    set_en,
   input  logic [ADDR_WIDTH-1:0]   set_idx,
   input  logic                    clr_en,
   input  logic [ADDR_WIDTH-1:0]   clr_idx,
   output logic [2**ADDR_WIDTH-1:0] pending,
   output logic [ADDR_WIDTH:0]     pending_count
);

   localparam int NUM_REGS = 2**ADDR_WIDTH;

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] pending_next;
   logic [ADDR_WIDTH:0] count_next;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && (set_idx != ADDR_WIDTH'(ZERO_REG)))
         set_mask[set_idx] = 1'b1;
      if (clr_en)
         clr_mask[clr_idx] = 1'b1;
      pending_next = (pending & ~clr_mask) | set_mask;
   end

   // Count the next-state vector so the count lands on the same edge as the bits.
   always_comb begin
      count_next = '0;
      for (int i = 0; i < NUM_REGS; i++)
         count_next = count_next + (ADDR_WIDTH+1)'(pending_next[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending       <= '0;
         pending_count <= '0;
      end else begin
         pending       <= pending_next;
         pending_count <= count_next;
      end
   end

endmodule

// File: rtl/mips_regfile_scoreboard.sv
// mips_regfile_scoreboard
// General-purpose register file with byte-lane writes and a pending-write scoreboard.
//   clk, reset            : clock, synchronous active-high reset (wins over writes/reservations)
//   rd_a_idx/rd_a_data    : async read port A (rs), hazard_a when the register is pending
//   rd_b_idx/rd_b_data    : async read port B (rt), hazard_b when the register is pending
//   wr_en/wr_idx/wr_byte_en/wr_data : synchronous write, only enabled byte lanes change
//   wr_clr_pending        : the write completes an outstanding reservation
//   rsv_en/rsv_idx        : mark a register pending
//   pending_count         : number of pending registers (registered)
//   dbg_reg_data          : stored contents of register DBG_REG (never bypassed)
// Optional build macro REGFILE_BYPASS_EN: a same-cycle write to a read index is
// forwarded (merged by lane) to that read port, and a completing write masks that
// port's hazard. Without it, reads and hazards see stored state only.
// Register 0 reads as zero, is never written and never reports a hazard.
module mips_regfile_scoreboard
   import mips_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DBG_REG    = DBG_V0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   rd_a_idx,
   input  logic [ADDR_WIDTH-1:0]   rd_b_idx,
   output logic [DATA_WIDTH-1:0]   rd_a_data,
   output logic [DATA_WIDTH-1:0]   rd_b_data,
   output logic                    hazard_a,
   output logic                    hazard_b,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_idx,
   input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    wr_clr_pending,
   input  logic                    rsv_en,
   input  logic [ADDR_WIDTH-1:0]   rsv_idx,
   output logic [ADDR_WIDTH:0]     pending_count,
   output logic [DATA_WIDTH-1:0]   dbg_reg_data
);

   localparam int NUM_REGS  = 2**ADDR_WIDTH;
   localparam int NUM_LANES = DATA_WIDTH/8;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   pending;
   logic [DATA_WIDTH-1:0] wr_old;
   logic [DATA_WIDTH-1:0] wr_merged;
   logic                  wr_live;
   logic [DATA_WIDTH-1:0] stored_a;
   logic [DATA_WIDTH-1:0] stored_b;

   assign wr_live = wr_en && (wr_idx != ADDR_WIDTH'(ZERO_REG));

   // Merged write value, shared by the register update and the bypass path.
   always_comb begin
      wr_old    = regs[wr_idx];
      wr_merged = wr_old;
      for (int i = 0; i < NUM_LANES; i++)
         wr_merged[8*i +: 8] = byte_merge(wr_old[8*i +: 8], wr_data[8*i +: 8], wr_byte_en[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (wr_live) begin
         regs[wr_idx] <= wr_merged;
      end
   end

   mips_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clk           (clk),
      .reset         (reset),
      .set_en        (rsv_en),
      .set_idx       (rsv_idx),
      .clr_en        (wr_en && wr_clr_pending),
      .clr_idx       (wr_idx),
      .pending       (pending),
      .pending_count (pending_count)
   );

   assign stored_a = (rd_a_idx == ADDR_WIDTH'(ZERO_REG)) ? '0 : regs[rd_a_idx];
   assign stored_b = (rd_b_idx == ADDR_WIDTH'(ZERO_REG)) ? '0 : regs[rd_b_idx];

`ifdef REGFILE_BYPASS_EN
   logic hit_a;
   logic hit_b;

   assign hit_a = wr_live && (wr_idx == rd_a_idx);
   assign hit_b = wr_live && (wr_idx == rd_b_idx);

   assign rd_a_data = hit_a ? wr_merged : stored_a;
   assign rd_b_data = hit_b ? wr_merged : stored_b;
   assign hazard_a  = pending[rd_a_idx] && !(hit_a && wr_clr_pending);
   assign hazard_b  = pending[rd_b_idx] && !(hit_b && wr_clr_pending);
`else
   assign rd_a_data = stored_a;
   assign rd_b_data = stored_b;
   assign hazard_a  = pending[rd_a_idx];
   assign hazard_b  = pending[rd_b_idx];
`endif

   assign dbg_reg_data = regs[DBG_REG];

endmodule
